// File: rtl/led_bar_pkg.sv
// led_bar_pkg: shared mode and peak-state encodings for the LED bar driver
package led_bar_pkg;
  localparam logic [1:0] MODE_BAR      = 2'd0;
  localparam logic [1:0] MODE_DOT      = 2'd1;
  localparam logic [1:0] MODE_BAR_PEAK = 2'd2;
  localparam logic [1:0] MODE_DOT_PEAK = 2'd3;
  typedef enum logic [1:0] {IDLE, HOLD, DECAY} peak_state_t;
endpackage

// File: rtl/led_level_decode.sv
// led_level_decode: level to thermometer (bar) and one-hot (dot) LED masks
module led_level_decode #(
  parameter int N_LEDS = 16,
  parameter int LW = $clog2(N_LEDS + 1)
) (
  input  logic [LW-1:0]     level,
  output logic [N_LEDS-1:0] therm,
  output logic [N_LEDS-1:0] onehot
);
  for (genvar i = 0; i < N_LEDS; i++) begin : g_bit
    assign therm[i]  = level > LW'(i);
    assign onehot[i] = level == LW'(i + 1);
  end
endmodule

// File: rtl/led_bar_driver.sv
// led_bar_driver: clamped level capture, peak hold/decay FSM and registered LED display mux
module led_bar_driver
  import led_bar_pkg::*;
#(
  parameter int N_LEDS = 16,
  parameter int LW = $clog2(N_LEDS + 1),
  parameter int HOLD_TICKS = 8,
  parameter int DECAY_TICKS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LW-1:0]     level_in,
  input  logic              level_valid,
  input  logic [1:0]        mode,
  input  logic              tick,
  input  logic              peak_clear,
  output logic [N_LEDS-1:0] led_out,
  output logic [LW-1:0]     peak_out,
  output logic              overflow
);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int DW = $clog2(DECAY_TICKS + 1);
  localparam logic [LW-1:0] NMAX = LW'(N_LEDS);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS - 1);
  localparam logic [DW-1:0] DECAY_LOAD = DW'(DECAY_TICKS - 1);
  peak_state_t state, state_n;
  logic [LW-1:0] lvl_q, lvl_n, peak_q, peak_n, peak_dec;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [DW-1:0] decay_cnt, decay_n;
  logic [N_LEDS-1:0] bar, dot, pk, led_n;
  logic over;
  assign over = level_valid && (level_in > NMAX);
  assign lvl_n = level_valid ? (over ? NMAX : level_in) : lvl_q;
  assign peak_dec = (peak_q - LW'(1)) > lvl_n ? peak_q - LW'(1) : lvl_n;
  always_comb begin
    state_n = state;
    peak_n = peak_q;
    hold_n = hold_cnt;
    decay_n = decay_cnt;
    if (peak_clear) begin
      state_n = IDLE;
      peak_n = '0;
      hold_n = '0;
      decay_n = '0;
    end else if (level_valid && lvl_n >= peak_q && lvl_n != '0) begin
      state_n = HOLD;
      peak_n = lvl_n;
      hold_n = HOLD_LOAD;
    end else if (tick && state == HOLD) begin
      state_n = hold_cnt == '0 ? DECAY : HOLD;
      hold_n = hold_cnt == '0 ? hold_cnt : hold_cnt - HW'(1);
      decay_n = hold_cnt == '0 ? DECAY_LOAD : decay_cnt;
    end else if (tick && state == DECAY && decay_cnt != '0) begin
      decay_n = decay_cnt - DW'(1);
    end else if (tick && state == DECAY) begin
      // Peak steps down one LED but never below the live level
      peak_n = peak_dec;
      state_n = peak_dec == '0 ? IDLE : (peak_dec == lvl_n ? HOLD : DECAY);
      hold_n = peak_dec == lvl_n ? HOLD_LOAD : hold_cnt;
      decay_n = DECAY_LOAD;
    end
  end
  led_level_decode #(.N_LEDS(N_LEDS), .LW(LW)) u_lvl_dec (
    .level(lvl_q), .therm(bar), .onehot(dot)
  );
  led_level_decode #(.N_LEDS(N_LEDS), .LW(LW)) u_peak_dec (
    .level(peak_q), .therm(), .onehot(pk)
  );
  always_comb
    led_n = mode == MODE_BAR ? bar :
            mode == MODE_DOT ? dot :
            mode == MODE_BAR_PEAK ? (bar | pk) : (dot | pk);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      lvl_q <= '0;
      peak_q <= '0;
      hold_cnt <= '0;
      decay_cnt <= '0;
      led_out <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      lvl_q <= lvl_n;
      peak_q <= peak_n;
      hold_cnt <= hold_n;
      decay_cnt <= decay_n;
      led_out <= led_n;
      overflow <= over;
    end
  end
  assign peak_out = peak_q;
endmodule

// File: tb/tb_led_bar_driver.sv
// tb_led_bar_driver: directed tests of capture, display modes and peak hold/decay
module tb_led_bar_driver;
  import led_bar_pkg::*;
  localparam int N = 16;
  localparam int LW = 5;
  logic clk = 0, rst_n = 0, level_valid = 0, tick = 0, peak_clear = 0;
  logic [LW-1:0] level_in = '0;
  logic [1:0] mode = MODE_BAR;
  logic [N-1:0] led_out;
  logic [LW-1:0] peak_out;
  logic overflow;
  int checks = 0, errors = 0;
  led_bar_driver #(.N_LEDS(N), .LW(LW), .HOLD_TICKS(4), .DECAY_TICKS(2)) dut (
    .clk(clk), .rst_n(rst_n), .level_in(level_in), .level_valid(level_valid),
    .mode(mode), .tick(tick), .peak_clear(peak_clear), .led_out(led_out),
    .peak_out(peak_out), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 0;
    cyc();
    rst_n = 1;
  endtask
  task automatic capture(input logic [LW-1:0] v);
    level_in = v;
    level_valid = 1;
    cyc();
    level_valid = 0;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1;
      cyc();
      tick = 0;
    end
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if (led_out !== 16'h0 || peak_out !== 5'd0 || overflow !== 1'b0 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL reset: led=%h peak=%0d ovf=%b state=%0d, want 0 0 0 IDLE", led_out, peak_out, overflow, dut.state);
    end
  endtask
  task automatic test_bar();
    mode = MODE_BAR;
    capture(5);
    checks++;
    if (overflow !== 1'b0 || peak_out !== 5'd5) begin
      errors++;
      $display("FAIL bar5_flags: ovf=%b peak=%0d, want 0 5", overflow, peak_out);
    end
    cyc();
    checks++;
    if (led_out !== 16'h001F) begin
      errors++;
      $display("FAIL bar5_led: got %h want 001f", led_out);
    end
  endtask
  task automatic test_overflow();
    capture(20);
    checks++;
    if (overflow !== 1'b1 || peak_out !== 5'd16) begin
      errors++;
      $display("FAIL ovf_capture: ovf=%b peak=%0d, want 1 16", overflow, peak_out);
    end
    cyc();
    checks++;
    if (overflow !== 1'b0 || led_out !== 16'hFFFF) begin
      errors++;
      $display("FAIL ovf_after: ovf=%b led=%h, want 0 ffff", overflow, led_out);
    end
  endtask
  task automatic test_dot();
    logic [LW-1:0] lv [3] = '{5'd0, 5'd1, 5'd16};
    logic [N-1:0] ex [3] = '{16'h0000, 16'h0001, 16'h8000};
    mode = MODE_DOT;
    for (int i = 0; i < 3; i++) begin
      capture(lv[i]);
      cyc();
      checks++;
      if (led_out !== ex[i]) begin
        errors++;
        $display("FAIL dot_%0d: got %h want %h", lv[i], led_out, ex[i]);
      end
    end
  endtask
  task automatic test_decay();
    do_reset();
    mode = MODE_BAR_PEAK;
    capture(12);
    capture(3);
    cyc();
    checks++;
    if (led_out !== 16'h0807) begin
      errors++;
      $display("FAIL bp_initial: got %h want 0807", led_out);
    end
    ticks(4);
    checks++;
    if (dut.state !== DECAY || peak_out !== 5'd12) begin
      errors++;
      $display("FAIL hold_expire: state=%0d peak=%0d, want DECAY 12", dut.state, peak_out);
    end
    ticks(2);
    checks++;
    if (peak_out !== 5'd11) begin
      errors++;
      $display("FAIL first_decay: got %0d want 11", peak_out);
    end
    cyc();
    checks++;
    if (led_out !== 16'h0407) begin
      errors++;
      $display("FAIL first_decay_led: got %h want 0407", led_out);
    end
    ticks(16);
    checks++;
    if (peak_out !== 5'd3 || dut.state !== HOLD) begin
      errors++;
      $display("FAIL decay_floor: peak=%0d state=%0d, want 3 HOLD", peak_out, dut.state);
    end
    cyc();
    checks++;
    if (led_out !== 16'h0007) begin
      errors++;
      $display("FAIL decay_floor_led: got %h want 0007", led_out);
    end
  endtask
  task automatic test_raise_in_decay();
    do_reset();
    mode = MODE_BAR_PEAK;
    capture(10);
    capture(2);
    ticks(9);
    checks++;
    if (peak_out !== 5'd8 || dut.state !== DECAY) begin
      errors++;
      $display("FAIL pre_raise: peak=%0d state=%0d, want 8 DECAY", peak_out, dut.state);
    end
    level_in = 9;
    level_valid = 1;
    tick = 1;
    cyc();
    level_valid = 0;
    tick = 0;
    checks++;
    if (peak_out !== 5'd9 || dut.state !== HOLD || dut.hold_cnt !== 3) begin
      errors++;
      $display("FAIL raise_vs_tick: peak=%0d state=%0d hold=%0d, want 9 HOLD 3", peak_out, dut.state, dut.hold_cnt);
    end
  endtask
  task automatic test_clear();
    mode = MODE_DOT_PEAK;
    level_in = 7;
    level_valid = 1;
    peak_clear = 1;
    cyc();
    level_valid = 0;
    peak_clear = 0;
    checks++;
    if (peak_out !== 5'd0 || dut.state !== IDLE || dut.lvl_q !== 5'd7) begin
      errors++;
      $display("FAIL clear: peak=%0d state=%0d lvl=%0d, want 0 IDLE 7", peak_out, dut.state, dut.lvl_q);
    end
    cyc();
    checks++;
    if (led_out !== 16'h0040) begin
      errors++;
      $display("FAIL clear_led: got %h want 0040", led_out);
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    mode = MODE_BAR;
    capture(20);
    capture(2);
    ticks(4);
    checks++;
    if (dut.state !== DECAY) begin
      errors++;
      $display("FAIL mid_setup: state=%0d want DECAY", dut.state);
    end
    rst_n = 0;
    tick = 1;
    cyc();
    rst_n = 1;
    tick = 0;
    checks++;
    if (led_out !== 16'h0 || peak_out !== 5'd0 || overflow !== 1'b0 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL mid_reset: led=%h peak=%0d ovf=%b state=%0d, want 0 0 0 IDLE", led_out, peak_out, overflow, dut.state);
    end
    cyc();
    checks++;
    if (led_out !== 16'h0 || peak_out !== 5'd0) begin
      errors++;
      $display("FAIL post_reset: led=%h peak=%0d, want 0 0", led_out, peak_out);
    end
  endtask
  initial begin
    cyc();
    test_reset();
    test_bar();
    test_overflow();
    test_dot();
    test_decay();
    test_raise_in_decay();
    test_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_bar_driver.md
Name: led_bar_driver

Overview:
Parametrised successor to the 16-LED bar-graph decoder. Maps a level value onto N_LEDS outputs in one of four display modes: bar, dot, bar+peak and dot+peak. Adds input clamping with an overflow flag, and a peak-hold/decay state machine paced by an external tick. Sits between the level/counter source and the board LED pins.

Parameters:
N_LEDS, 16, number of LED outputs (2..64)
LW, $clog2(N_LEDS+1), width of level and peak values
HOLD_TICKS, 8, ticks the peak is frozen before decay starts (>=1)
DECAY_TICKS, 4, ticks per one-LED peak decrement (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
level_in  in  LW  requested level; number of lit bar LEDs
level_valid  in  1  capture strobe for level_in
mode  in  2  0=BAR, 1=DOT, 2=BAR_PEAK, 3=DOT_PEAK
tick  in  1  one-cycle pacing pulse from a prescaler
peak_clear  in  1  force peak to 0
led_out  out  N_LEDS  registered LED drive; bit 0 = first LED
peak_out  out  LW  current peak value
overflow  out  1  one-cycle pulse when level_in > N_LEDS was captured

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n); it is sampled only on the clk edge.
- Reset values: lvl_q=0, peak_q=0, state=IDLE, hold/decay counters=0, led_out=0, peak_out=0, overflow=0. Reset asserted mid-operation (including in HOLD or DECAY) forces these values at the next edge.
- Capture: when level_valid=1, the clamped level lvl_n = min(level_in, N_LEDS) is loaded into lvl_q.
  - overflow is registered high for exactly 1 cycle when level_in > N_LEDS; otherwise 0.
  - When level_valid=0, lvl_n = lvl_q.
- Peak FSM (states IDLE, HOLD, DECAY). All comparisons use lvl_n. Priority: reset > peak_clear > capture-raise > tick.
  - peak_clear=1: peak_q=0, go to IDLE. This applies even when level_valid is high in the same cycle; lvl_q still captures.
  - Capture-raise: level_valid=1, lvl_n >= peak_q and lvl_n > 0 → peak_q=lvl_n, go to HOLD, hold_cnt=HOLD_TICKS-1. This applies from any state and takes precedence over a simultaneous tick.
  - IDLE: peak_q=0; leaves only via capture-raise.
  - HOLD, tick=1: if hold_cnt=0 → go to DECAY, decay_cnt=DECAY_TICKS-1; else hold_cnt-1.
  - DECAY, tick=1: if decay_cnt>0 → decay_cnt-1.
  - DECAY, tick=1, decay_cnt=0: peak_q = max(peak_q-1, lvl_n), then:
    - new peak = 0 → IDLE;
    - new peak = lvl_n > 0 → HOLD with hold_cnt reloaded;
    - otherwise stay in DECAY with decay_cnt reloaded.
  - tick=0: counters and peak_q unchanged.
- Display decode, computed from lvl_q, peak_q and mode:
  - bar = lowest lvl_q bits set.
  - dot = bit lvl_q-1 only; all zero when lvl_q=0.
  - pk = bit peak_q-1 only; all zero when peak_q=0.
  - BAR=bar, DOT=dot, BAR_PEAK=bar|pk, DOT_PEAK=dot|pk.
- Latency: led_out is registered from the current lvl_q/peak_q.
  - level_valid sampled at edge k → lvl_q at k → led_out at edge k+1.
  - A mode change is visible one edge later.
  - peak_out equals peak_q (register output, no extra latency).
- Boundaries: level_in=0 → bar and dot all zero. level_in=N_LEDS → all LEDs in BAR; top LED only in DOT. Peak never drops below lvl_n and never exceeds N_LEDS. Counters never wrap.

Decomposition:
- Package led_bar_pkg: mode encoding constants (MODE_BAR/DOT/BAR_PEAK/DOT_PEAK) and the peak state encoding (IDLE/HOLD/DECAY).
- Sub-module led_level_decode, parameter N_LEDS, combinational:
  - inputs: level;
  - outputs: thermometer mask and one-hot mask.
  - Instantiated twice: once for level, once for peak (one-hot only used).
- Top: capture/clamp register, peak FSM with hold/decay counters, output mux and register.

Test Plan (N_LEDS=16, HOLD_TICKS=4, DECAY_TICKS=2):
- Reset, then BAR mode, capture level 5 → led_out=0x001F two edges after strobe; overflow=0; peak_out=5.
- BAR mode, capture level 20 → led_out=0xFFFF; overflow high exactly 1 cycle; peak_out=16. DOT mode, capture 0 → 0x0000; capture 1 → 0x0001; capture 16 → 0x8000.
- BAR_PEAK mode, capture 12 then 3 → led_out=0x0807.
  - After 4 ticks: state DECAY.
  - After 2 more ticks: peak_out=11, led_out=0x0407.
  - Continues down to peak 3, then HOLD with led_out=0x0007.
- Capture 10 → hold; during DECAY at peak 8, capture 9 in the same cycle as an expiring tick → peak_out=9, state HOLD, hold counter reloaded.
- Capture 7 with peak_clear in the same cycle → lvl_q=7, peak_out=0, state IDLE; DOT_PEAK led_out=0x0040.
- Assert rst_n=0 mid-DECAY for one edge → all outputs 0 and state IDLE at that edge; a tick during reset has no effect.
